// File: rtl/cmn_iq_pkg.sv
// Shared helpers for the age-ordered issue queue.
// Pure declarations; no timing or flow control.
package cmn_iq_pkg;

    function automatic int IQ_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmn_age_matrix.sv
// Relative-age matrix: row i bit j set means entry i is younger than entry j.
// Updates one cycle after alloc_en; never stalls.
module cmn_age_matrix #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_en,
    input  logic [WIDTH-1:0]         v_alloc,
    output logic [WIDTH*WIDTH-1:0]   matrix
);

    logic [WIDTH*WIDTH-1:0] r_matrix;

    // A new entry is younger than every existing entry and than lower-index peers allocated alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_matrix <= '0;
        end else if (alloc_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (v_alloc[i])
                        r_matrix[i*WIDTH+j] <= (i != j) && (!v_alloc[j] || (j < i));
                    else if (v_alloc[j])
                        r_matrix[i*WIDTH+j] <= 1'b0;
                end
            end
        end
    end

    assign matrix = r_matrix;

endmodule

// File: rtl/cmn_oldest_sel.sv
// One-hot pick of the oldest ready entry from an age matrix.
// Purely combinational; no backpressure.
module cmn_oldest_sel #(
    parameter int N = 8
) (
    input  logic [N-1:0]   i_ready,
    input  logic [N*N-1:0] i_matrix,
    output logic [N-1:0]   o_oldest_oh
);

    always_comb begin
        for (int i = 0; i < N; i++)
            o_oldest_oh[i] = i_ready[i] & ~|(i_matrix[i*N +: N] & i_ready);
    end

endmodule

// File: rtl/cmn_age_issue_queue.sv
// Issue queue: tag wakeup, oldest-ready select, one issue per cycle.
// Alloc/issue take effect at the next edge; flush overrides both.
module cmn_age_issue_queue
    import cmn_iq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int NSRC   = 2,
    parameter int WAKE_N = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_vld,
    output logic                          alloc_rdy,
    input  logic [DATA_W-1:0]             alloc_data,
    input  logic [NSRC*TAG_W-1:0]         alloc_src_tag,
    input  logic [NSRC-1:0]               alloc_src_rdy,
    input  logic [WAKE_N-1:0]             wake_vld,
    input  logic [WAKE_N*TAG_W-1:0]       wake_tag,
    output logic                          issue_vld,
    input  logic                          issue_rdy,
    output logic [DATA_W-1:0]             issue_data,
    output logic [IQ_IDX_W(DEPTH)-1:0]    issue_idx,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int IDX_W = IQ_IDX_W(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic                    valid;
        logic [DATA_W-1:0]       payload;
        logic [NSRC*TAG_W-1:0]   tags;
        logic [NSRC-1:0]         src_rdy;
    } iq_entry_t;

    iq_entry_t              r_ent [DEPTH];
    logic [CNT_W-1:0]       r_count;

    logic [DEPTH-1:0]       w_valid;
    logic [DEPTH-1:0]       w_ready;
    logic [DEPTH-1:0]       w_free_oh;
    logic [DEPTH-1:0]       w_sel_oh;
    logic [DEPTH*DEPTH-1:0] w_matrix;
    logic [NSRC-1:0]        w_wake_rdy [DEPTH];
    logic [NSRC-1:0]        w_alloc_src_rdy;
    logic                   w_alloc_fire;
    logic                   w_issue_fire;

    function automatic logic tag_hit(input logic [TAG_W-1:0]        tag,
                                     input logic [WAKE_N-1:0]       vld,
                                     input logic [WAKE_N*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_N; p++)
            hit = hit | (vld[p] && (tags[p*TAG_W +: TAG_W] == tag));
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]    = r_ent[i].valid;
            w_ready[i]    = r_ent[i].valid & (&r_ent[i].src_rdy);
            w_wake_rdy[i] = r_ent[i].src_rdy;
            for (int k = 0; k < NSRC; k++)
                if (tag_hit(r_ent[i].tags[k*TAG_W +: TAG_W], wake_vld, wake_tag))
                    w_wake_rdy[i][k] = 1'b1;
        end
        for (int k = 0; k < NSRC; k++)
            w_alloc_src_rdy[k] = alloc_src_rdy[k]
                               | tag_hit(alloc_src_tag[k*TAG_W +: TAG_W], wake_vld, wake_tag);
    end

    // Lowest clear bit of the valid vector.
    assign w_free_oh    = ~w_valid & (w_valid + DEPTH'(1));
    assign alloc_rdy    = (|(~w_valid)) & ~flush;
    assign w_alloc_fire = alloc_vld & alloc_rdy;
    assign issue_vld    = |w_ready;
    assign w_issue_fire = issue_vld & issue_rdy & ~flush;
    assign count        = r_count;

    cmn_age_matrix #(.WIDTH(DEPTH)) u_age (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc_en (w_alloc_fire),
        .v_alloc  (w_free_oh),
        .matrix   (w_matrix)
    );

    cmn_oldest_sel #(.N(DEPTH)) u_sel (
        .i_ready     (w_ready),
        .i_matrix    (w_matrix),
        .o_oldest_oh (w_sel_oh)
    );

    always_comb begin
        issue_idx  = '0;
        issue_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_oh[i]) begin
                issue_idx  = issue_idx | IDX_W'(i);
                issue_data = issue_data | r_ent[i].payload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_ent[i] <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush || (w_issue_fire && w_sel_oh[i])) begin
                    r_ent[i].valid   <= 1'b0;
                    r_ent[i].src_rdy <= '0;
                end else if (w_alloc_fire && w_free_oh[i]) begin
                    r_ent[i].valid   <= 1'b1;
                    r_ent[i].payload <= alloc_data;
                    r_ent[i].tags    <= alloc_src_tag;
                    r_ent[i].src_rdy <= w_alloc_src_rdy;
                end else if (r_ent[i].valid) begin
                    r_ent[i].src_rdy <= w_wake_rdy[i];
                end
            end
            if (flush)
                r_count <= '0;
            else
                r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_issue_fire);
        end
    end

endmodule
